rds_block_sync: RTL
===================

# rds_block_sync

Receive-side RDS block synchronizer and checker: the receiving counterpart of the FM/RDS transmit chain. It sits after an RDS demodulator/bit slicer and takes a serial stream of differentially decoded data bits with a valid strobe. It finds 26-bit block boundaries using the offset-word checkwords and tracks the A→B→C/C'→D sequence. It delivers each 16-bit information word with its block identity and an error flag.

## Interface
- `c_bad_limit`, default 8: number of consecutive bad blocks in SYNC that drops lock (range 1..31).
- `clk`  in  1  system clock (25 MHz domain); all logic rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `bit_in`  in  1  received data bit, MSB of each block first.
- `bit_valid`  in  1  one-cycle strobe; `bit_in` is sampled only when high; may be high on consecutive cycles.
- `block_data`  out  16  information word of the last emitted block.
- `block_id`  out  3  0=A, 1=B, 2=C, 3=C', 4=D.
- `block_valid`  out  1  one-cycle strobe; `block_data`/`block_id`/`block_err` are valid with it.
- `block_err`  out  1  1 = checkword mismatch (data passed through raw).
- `synced`  out  1  high while in SYNC.

## Operation
- 26-bit shift register `sr`, shifted left with `bit_in` on each `bit_valid`. Window: info = sr[25:10], chk = sr[9:0].
- Checkword rule: calc = remainder of (info · x^10) mod g(x), where g(x) = x^10+x^8+x^7+x^5+x^4+x^3+1. Window matches offset k when (chk XOR calc) == offset[k]. Offsets: A=0x0FC, B=0x198, C=0x168, C'=0x350, D=0x1B4. Evaluation is combinational on the post-shift value.
- Successor of the expected block: A→B, B→C (C or C' both accepted), C/C'→D, D→A.
- Bit counter `bc` (0..25) counts `bit_valid` strobes since the last block boundary.
- States:
  - SEARCH: on every bit, test all five offsets. On a match, record the successor as expected, set bc=0, and go to ACQ. No output.
  - ACQ: when bc reaches 26 bits:
    - If the window matches the expected offset, go to SYNC, emit that block with err=0, and raise `synced`.
    - Otherwise, re-evaluate the same window as in SEARCH: on any match, restart ACQ from it; else go to SEARCH.
  - SYNC: every 26th bit, emit a block.
    - Match on the expected offset (C or C' at the C slot): err=0, id = matched, bad counter cleared.
    - No match: err=1, id = expected (2 at the C slot), bad counter +1.
    - When the bad counter reaches `c_bad_limit`: go to SEARCH, drop `synced` in the same cycle as that failing block's strobe, and clear the bad counter.
    - Expected always advances to the successor.
- No error correction is performed.

## Timing
- Reset values: block_data=0, block_id=0, block_valid=0, block_err=0, synced=0, state=SEARCH, sr=0, bc=0, bad counter=0.
- Latency: block_valid is high in the cycle after the `bit_valid` cycle that delivered a block's 26th bit, i.e. 1 clk.
- Outputs hold their values between strobes; block_valid is never high for two consecutive cycles unless bit_valid was.
- `synced` rises together with the first SYNC strobe and falls together with the c_bad_limit-th consecutive bad strobe.
- Reset asserted mid-block: everything is discarded; a block completing in the reset cycle is not emitted.
- bit_valid low: all state frozen.

## Test plan
- Clean stream: 7 random lead-in bits, then groups A=0xC201, B=0x0408, C=0x1234, D=0x5678 with correct checkwords → first strobe is B (0x0408, id 1, err 0) with synced=1; every subsequent 26th bit gives A/B/C/D ids 0,1,2,4 in order.
- C' variant: group with C' offset, data 0xC201 → id 3, err 0, lock kept.
- Single bit flip in a D block while synced → that strobe has id 4, err=1, raw data; the next A block has err=0 and synced stays 1.
- c_bad_limit=8: after lock, feed 8 blocks of random bits → 8 strobes with err=1; synced falls with the 8th; no strobes follow until re-acquisition from clean groups (two good blocks).
- False match: random bits forming a valid A window, followed by a non-B window 26 bits later → no strobe, returns to SEARCH, synced stays 0.
- Reset asserted at bit 13 of a synced block → all outputs 0 next cycle; clean groups after reset re-lock on the second block.

Source files
------------

// File: rtl/rds_block_sync.sv
// rds_block_sync: receive-side RDS block synchronizer and checker.
// Shifts in the demodulated bit stream, finds 26-bit block boundaries from the
// offset-word checkwords, tracks the A -> B -> C/C' -> D sequence and emits
// each 16-bit information word with its block id and a checkword-error flag.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-high reset
//   bit_in       received bit, MSB of each block first
//   bit_valid    one-cycle strobe qualifying bit_in
//   block_data   information word of the last emitted block
//   block_id     0=A, 1=B, 2=C, 3=C', 4=D
//   block_valid  one-cycle strobe qualifying block_data/block_id/block_err
//   block_err    1 = checkword mismatch, data passed through raw
//   synced       high while locked
module rds_block_sync #(
  parameter int unsigned c_bad_limit = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bit_in,
  input  logic        bit_valid,
  output logic [15:0] block_data,
  output logic [2:0]  block_id,
  output logic        block_valid,
  output logic        block_err,
  output logic        synced
);

  localparam int unsigned SR_W   = 26;
  localparam int unsigned INFO_W = 16;
  localparam int unsigned CHK_W  = 10;
  localparam int unsigned BC_W   = 5;
  localparam int unsigned BAD_W  = 5;
  localparam int unsigned ID_W   = 3;

  localparam logic [BC_W-1:0] BC_LAST = BC_W'(SR_W - 1);

  // Low ten bits of g(x) = x^10+x^8+x^7+x^5+x^4+x^3+1
  localparam logic [CHK_W-1:0] GEN_POLY = 10'h1B9;

  localparam logic [CHK_W-1:0] OFF_A  = 10'h0FC;
  localparam logic [CHK_W-1:0] OFF_B  = 10'h198;
  localparam logic [CHK_W-1:0] OFF_C  = 10'h168;
  localparam logic [CHK_W-1:0] OFF_CP = 10'h350;
  localparam logic [CHK_W-1:0] OFF_D  = 10'h1B4;

  localparam logic [ID_W-1:0] ID_A  = 3'd0;
  localparam logic [ID_W-1:0] ID_B  = 3'd1;
  localparam logic [ID_W-1:0] ID_C  = 3'd2;
  localparam logic [ID_W-1:0] ID_CP = 3'd3;
  localparam logic [ID_W-1:0] ID_D  = 3'd4;

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_ACQ    = 2'd1;
  localparam logic [1:0] ST_SYNC   = 2'd2;

  logic [1:0]        state, state_n;
  logic [SR_W-1:0]   sr, sr_n;
  logic [BC_W-1:0]   bc, bc_n;
  logic [BAD_W-1:0]  bad, bad_n;
  logic [ID_W-1:0]   exp_id, exp_id_n;
  logic [INFO_W-1:0] data_n;
  logic [ID_W-1:0]   id_n;
  logic              valid_n, err_n, synced_n;

  logic [SR_W-1:0]   sr_shift;
  logic [CHK_W-1:0]  syndrome;
  logic [4:0]        hit;
  logic              any_hit;
  logic [ID_W-1:0]   hit_id;
  logic              exp_hit;
  logic [ID_W-1:0]   exp_match_id;
  logic [BAD_W-1:0]  bad_inc;

  // Remainder of info * x^10 mod g(x), bit-serial MSB first
  function automatic logic [CHK_W-1:0] chk_calc(input logic [INFO_W-1:0] info);
    logic [CHK_W-1:0] rem;
    logic             fb;
    rem = '0;
    for (int i = INFO_W - 1; i >= 0; i--) begin
      fb  = rem[CHK_W-1] ^ info[i];
      rem = {rem[CHK_W-2:0], 1'b0};
      if (fb) rem = rem ^ GEN_POLY;
    end
    return rem;
  endfunction

  // Block that follows a given block in the group sequence
  function automatic logic [ID_W-1:0] succ(input logic [ID_W-1:0] id);
    case (id)
      ID_A:        succ = ID_B;
      ID_B:        succ = ID_C;
      ID_C, ID_CP: succ = ID_D;
      default:     succ = ID_A;
    endcase
  endfunction

  // Offset detection on the window as it will be after this bit shifts in
  always_comb begin
    sr_shift = {sr[SR_W-2:0], bit_in};
    syndrome = sr_shift[CHK_W-1:0] ^ chk_calc(sr_shift[SR_W-1:CHK_W]);
    hit[0]   = (syndrome == OFF_A);
    hit[1]   = (syndrome == OFF_B);
    hit[2]   = (syndrome == OFF_C);
    hit[3]   = (syndrome == OFF_CP);
    hit[4]   = (syndrome == OFF_D);
    any_hit  = |hit;
    // Offsets are distinct, so at most one bit of hit is set
    hit_id = ID_A;
    if (hit[1]) hit_id = ID_B;
    if (hit[2]) hit_id = ID_C;
    if (hit[3]) hit_id = ID_CP;
    if (hit[4]) hit_id = ID_D;
    case (exp_id)
      ID_A:    exp_hit = hit[0];
      ID_B:    exp_hit = hit[1];
      ID_C:    exp_hit = hit[2] | hit[3];
      ID_D:    exp_hit = hit[4];
      default: exp_hit = 1'b0;
    endcase
    // At the C slot the id reports which of C / C' actually matched
    exp_match_id = (exp_id == ID_C && hit[3]) ? ID_CP : exp_id;
    bad_inc      = bad + BAD_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_SEARCH;
      sr          <= '0;
      bc          <= '0;
      bad         <= '0;
      exp_id      <= ID_A;
      block_data  <= '0;
      block_id    <= '0;
      block_valid <= 1'b0;
      block_err   <= 1'b0;
      synced      <= 1'b0;
    end else begin
      state       <= state_n;
      sr          <= sr_n;
      bc          <= bc_n;
      bad         <= bad_n;
      exp_id      <= exp_id_n;
      block_data  <= data_n;
      block_id    <= id_n;
      block_valid <= valid_n;
      block_err   <= err_n;
      synced      <= synced_n;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_n  = state;
    sr_n     = sr;
    bc_n     = bc;
    bad_n    = bad;
    exp_id_n = exp_id;
    data_n   = block_data;
    id_n     = block_id;
    valid_n  = 1'b0;
    err_n    = block_err;
    synced_n = synced;

    if (bit_valid) begin
      sr_n = sr_shift;
      case (state)
        ST_SEARCH: begin
          if (any_hit) begin
            exp_id_n = succ(hit_id);
            bc_n     = '0;
            state_n  = ST_ACQ;
          end
        end

        ST_ACQ: begin
          if (bc == BC_LAST) begin
            bc_n = '0;
            if (exp_hit) begin
              state_n  = ST_SYNC;
              valid_n  = 1'b1;
              data_n   = sr_shift[SR_W-1:CHK_W];
              id_n     = exp_match_id;
              err_n    = 1'b0;
              synced_n = 1'b1;
              bad_n    = '0;
              exp_id_n = succ(exp_id);
            end else if (any_hit) begin
              // Candidate boundary was wrong; restart from the new match
              exp_id_n = succ(hit_id);
            end else begin
              state_n = ST_SEARCH;
            end
          end else begin
            bc_n = bc + BC_W'(1);
          end
        end

        ST_SYNC: begin
          if (bc == BC_LAST) begin
            bc_n     = '0;
            valid_n  = 1'b1;
            data_n   = sr_shift[SR_W-1:CHK_W];
            exp_id_n = succ(exp_id);
            if (exp_hit) begin
              id_n  = exp_match_id;
              err_n = 1'b0;
              bad_n = '0;
            end else begin
              id_n  = exp_id;
              err_n = 1'b1;
              if (bad_inc == BAD_W'(c_bad_limit)) begin
                state_n  = ST_SEARCH;
                synced_n = 1'b0;
                bad_n    = '0;
              end else begin
                bad_n = bad_inc;
              end
            end
          end else begin
            bc_n = bc + BC_W'(1);
          end
        end

        default: begin
          state_n  = ST_SEARCH;
          synced_n = 1'b0;
        end
      endcase
    end
  end

endmodule
